// File: rtl/llc_pkg.sv
// Shared CAN/LLC constants: field widths and the layout of one stored receive frame.
package llc_pkg;

  localparam int CAN_IDW   = 29;
  localparam int CAN_DATAW = 64;
  localparam int CAN_DLCW  = 4;

  // Stored entry layout, MSB first: {id, ide, rtr, dlc, data}.
  localparam int FRAME_W      = CAN_IDW + 1 + 1 + CAN_DLCW + CAN_DATAW;
  localparam int FRAME_DLC_LO = CAN_DATAW;
  localparam int FRAME_RTR    = CAN_DATAW + CAN_DLCW;
  localparam int FRAME_IDE    = CAN_DATAW + CAN_DLCW + 1;
  localparam int FRAME_ID_LO  = CAN_DATAW + CAN_DLCW + 2;

  function automatic int frame_width(input int idw, input int dataw);
    return idw + 2 + CAN_DLCW + dataw;
  endfunction

endpackage

// File: rtl/llc_frame_ram.sv
// DEPTH x W register array: one synchronous write port, one combinational read port.
module llc_frame_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 98,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; the top masks the read data while the FIFO is empty,
  // so stale contents are never observable and the array can map to plain flops/RAM.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/llc_recv_fifo.sv
// Receive-frame FIFO behind llc_fsm2: one entry per activrreg window, CPU pops the head.
module llc_recv_fifo
  import llc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDW   = CAN_IDW,
  parameter int DATAW = CAN_DATAW,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             activrreg,
  input  logic [IDW-1:0]   rec_id,
  input  logic             rec_ide,
  input  logic             rec_rtr,
  input  logic [3:0]       rec_dlc,
  input  logic [DATAW-1:0] rec_data,
  input  logic             pop,
  input  logic             clrovf,
  output logic [IDW-1:0]   rd_id,
  output logic             rd_ide,
  output logic             rd_rtr,
  output logic [3:0]       rd_dlc,
  output logic [DATAW-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             irq
);

  localparam int FW = frame_width(IDW, DATAW);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic          activrreg_d;
  logic [AW-1:0] wptr, rptr;
  logic          push, do_pop, accept, drop;
  logic [FW-1:0] wframe, rframe, head;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // A pop on a full FIFO frees the slot at the same edge, so a coincident push is accepted.
  assign push   = activrreg & ~activrreg_d;
  assign do_pop = pop & ~empty;
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  assign wframe = {rec_id, rec_ide, rec_rtr, rec_dlc, rec_data};

  llc_frame_ram #(.DEPTH(DEPTH), .W(FW)) u_ram (
    .clock (clock),
    .we    (accept),
    .waddr (wptr),
    .wdata (wframe),
    .raddr (rptr),
    .rdata (rframe)
  );

  // NOTE: non-blocking assignments for every register, so all state updates see
  // the pre-edge values of count/pointers regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      activrreg_d <= 1'b0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      irq         <= 1'b0;
    end else begin
      activrreg_d <= activrreg;
      irq         <= accept;
      if (accept) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      case ({accept, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)        ovf <= 1'b1;
      else if (clrovf) ovf <= 1'b0;
    end
  end

  // NOTE: head gets a default before the conditional override, so no latch is inferred.
  always_comb begin
    head = '0;
    if (!empty) head = rframe;
  end

  assign rd_data = head[DATAW-1:0];
  assign rd_dlc  = head[DATAW+3:DATAW];
  assign rd_rtr  = head[DATAW+4];
  assign rd_ide  = head[DATAW+5];
  assign rd_id   = head[FW-1:DATAW+6];

endmodule

// File: tb/tb_llc_recv_fifo.sv
// Directed self-checking bench for llc_recv_fifo (DEPTH=4, 29-bit ID, 64-bit data).
module tb_llc_recv_fifo;

  logic        clock = 1'b0;
  logic        reset;
  logic        activrreg;
  logic [28:0] rec_id;
  logic        rec_ide, rec_rtr;
  logic [3:0]  rec_dlc;
  logic [63:0] rec_data;
  logic        pop, clrovf;
  logic [28:0] rd_id;
  logic        rd_ide, rd_rtr;
  logic [3:0]  rd_dlc;
  logic [63:0] rd_data;
  logic [2:0]  count;
  logic        empty, full, ovf, irq;

  int checks = 0;
  int errors = 0;
  int irqs;

  llc_recv_fifo #(.DEPTH(4), .IDW(29), .DATAW(64)) dut (
    .clock     (clock),
    .reset     (reset),
    .activrreg (activrreg),
    .rec_id    (rec_id),
    .rec_ide   (rec_ide),
    .rec_rtr   (rec_rtr),
    .rec_dlc   (rec_dlc),
    .rec_data  (rec_data),
    .pop       (pop),
    .clrovf    (clrovf),
    .rd_id     (rd_id),
    .rd_ide    (rd_ide),
    .rd_rtr    (rd_rtr),
    .rd_dlc    (rd_dlc),
    .rd_data   (rd_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .ovf       (ovf),
    .irq       (irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One reception window of len cycles; returns the number of irq pulses seen.
  task automatic window(input logic [28:0] id, input logic [3:0] dlc,
                        input logic [63:0] data, input int len, output int n_irq);
    n_irq     = 0;
    rec_id    = id;
    rec_dlc   = dlc;
    rec_data  = data;
    activrreg = 1'b1;
    for (int i = 0; i < len; i++) begin
      tick();
      n_irq += int'(irq);
    end
    activrreg = 1'b0;
    tick();
    n_irq += int'(irq);
  endtask

  task automatic pop_one();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; activrreg = 1'b0; rec_id = '0; rec_ide = 1'b0; rec_rtr = 1'b0;
    rec_dlc = '0; rec_data = '0; pop = 1'b0; clrovf = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    check("rst_count", 64'(count), 0);
    check("rst_empty", 64'(empty), 1);
    check("rst_full",  64'(full),  0);
    check("rst_ovf",   64'(ovf),   0);
    check("rst_irq",   64'(irq),   0);
    check("rst_rd_id", 64'(rd_id), 0);

    // 1: single 5-cycle window
    window(29'h123, 4'd2, 64'hAABB_0000_0000_0000, 5, irqs);
    check("t1_irqs",    64'(irqs),   1);
    check("t1_count",   64'(count),  1);
    check("t1_rd_id",   64'(rd_id),  64'h123);
    check("t1_rd_dlc",  64'(rd_dlc), 2);
    check("t1_rd_data", rd_data,     64'hAABB_0000_0000_0000);
    check("t1_empty",   64'(empty),  0);
    pop_one();
    check("t1_popped",  64'(count),  0);

    // 2: fill, overflow drop, drain
    for (int i = 1; i <= 4; i++) begin
      window(29'(i), 4'(i), 64'(i) << 8, 2, irqs);
      check($sformatf("t2_irq%0d", i), 64'(irqs), 1);
    end
    window(29'd5, 4'd5, 64'h5, 2, irqs);
    check("t2_drop_irq", 64'(irqs),  0);
    check("t2_full",     64'(full),  1);
    check("t2_ovf",      64'(ovf),   1);
    check("t2_count",    64'(count), 4);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("t2_head%0d", i), 64'(rd_id), 64'(i));
      pop_one();
    end
    check("t2_empty",   64'(empty),   1);
    check("t2_rd_id0",  64'(rd_id),   0);
    check("t2_rd_dlc0", 64'(rd_dlc),  0);
    check("t2_rd_dat0", rd_data,      0);
    clrovf = 1'b1; tick(); clrovf = 1'b0;
    check("t2_clrovf",  64'(ovf),     0);

    // 3: push and pop together on a full FIFO
    for (int i = 1; i <= 4; i++) window(29'(i), 4'd1, 64'(i), 2, irqs);
    rec_id = 29'd9; activrreg = 1'b1; pop = 1'b1;
    tick();
    check("t3_count", 64'(count), 4);
    check("t3_irq",   64'(irq),   1);
    check("t3_ovf",   64'(ovf),   0);
    check("t3_head",  64'(rd_id), 2);
    pop = 1'b0; activrreg = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_drain%0d", i), 64'(rd_id), (i == 3) ? 64'd9 : 64'(i + 2));
      pop_one();
    end
    check("t3_empty", 64'(empty), 1);

    // 4: pop on empty, then push+pop on empty
    pop_one();
    check("t4_pop_count", 64'(count), 0);
    check("t4_pop_empty", 64'(empty), 1);
    rec_id = 29'h1ABC_DEF; rec_ide = 1'b1; rec_rtr = 1'b1; rec_dlc = 4'd15;
    rec_data = 64'h0123_4567_89AB_CDEF; activrreg = 1'b1; pop = 1'b1;
    tick();
    pop = 1'b0; activrreg = 1'b0; rec_ide = 1'b0; rec_rtr = 1'b0;
    check("t4_pp_count", 64'(count),  1);
    check("t4_pp_id",    64'(rd_id),  64'h1ABC_DEF);
    check("t4_pp_ide",   64'(rd_ide), 1);
    check("t4_pp_rtr",   64'(rd_rtr), 1);
    check("t4_pp_dlc",   64'(rd_dlc), 15);
    check("t4_pp_data",  rd_data,     64'h0123_4567_89AB_CDEF);
    tick();
    pop_one();

    // 5: drop and clrovf in the same cycle
    for (int i = 1; i <= 5; i++) window(29'(i + 16), 4'd3, 64'(i), 2, irqs);
    check("t5_ovf_set", 64'(ovf), 1);
    rec_id = 29'd30; activrreg = 1'b1; clrovf = 1'b1;
    tick();
    check("t5_set_wins", 64'(ovf),   1);
    check("t5_count",    64'(count), 4);
    activrreg = 1'b0;
    tick();
    check("t5_cleared",  64'(ovf),   0);
    clrovf = 1'b0;

    // 6: reset during a window with 2 frames stored
    pop_one(); pop_one();
    check("t6_pre_count", 64'(count), 2);
    rec_id = 29'd40; activrreg = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check("t6_rst_count", 64'(count), 0);
    check("t6_rst_empty", 64'(empty), 1);
    check("t6_rst_ovf",   64'(ovf),   0);
    reset = 1'b0;
    tick();
    check("t6_rel_count", 64'(count), 1);
    check("t6_rel_irq",   64'(irq),   1);
    check("t6_rel_id",    64'(rd_id), 40);
    tick();
    check("t6_one_write", 64'(count), 1);
    activrreg = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
